tick_btn_conditioner: RTL and testbench

Upstream conditioning stage for the traffic-light sequencer. It divides the system clock into a one-cycle `roll` pulse per second and turns the raw pedestrian push-button into a synchronized, debounced, single-cycle `btn` pulse. It also enforces a post-request lockout so repeated presses cannot restart the sequence. Both outputs are registered and glitch-free, so the sequencer can use them as edge sources.

---
 rtl/tick_btn_conditioner.sv | 174 +++++++++++++++++
 tb/tb_tick_btn_conditioner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_btn_conditioner.sv
// Upstream conditioning for the traffic-light sequencer: one-second roll tick,
// synchronized/debounced single-cycle button pulse, and post-request lockout.
module tick_btn_conditioner #(
    parameter int unsigned TICK_DIV      = 10_000_000,
    parameter int unsigned DEB_CYCLES    = 200_000,
    parameter int unsigned LOCKOUT_TICKS = 22
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ena,
    input  logic btn_raw,
    output logic roll,
    output logic btn,
    output logic btn_stable,
    output logic lockout_active
);

    localparam int unsigned DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned LOCK_W = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCKOUT_TICKS);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_PRESSED = 2'd2,
        S_WAIT_LO = 2'd3
    } deb_state_e;

    logic [1:0]        sync_q;
    logic              bs;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick_c;
    deb_state_e        state_q, state_d;
    logic [DEB_W-1:0]  cnt_q, cnt_d;
    logic              press_q, press_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              defer_q, defer_d;
    logic              lock_zero_c, lock_free_c, accept_c;
    logic              roll_q, roll_d;
    logic              btn_q, btn_d;
    logic              stable_q, stable_d;
    logic              lockact_q, lockact_d;

    assign bs = sync_q[1];

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // Tick divider: counts enabled cycles, raises tick_c on wrap
    always_comb begin
        div_d  = div_q;
        tick_c = 1'b0;
        if (ena) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_c = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Debounce FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Debounce FSM next state; press event fires on entry to PRESSED from WAIT_HI
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bs) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HI: begin
                if (!bs) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            S_PRESSED: begin
                if (!bs) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LO: begin
                if (bs) begin
                    state_d = S_PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Press acceptance, lockout counting and roll/btn collision steering.
    // A press is also accepted when the roll issued this cycle takes the
    // counter from 1 to 0.
    always_comb begin
        lock_zero_c = (lock_q == '0);
        lock_free_c = lock_zero_c || ((lock_q == LOCK_ONE) && (tick_c || defer_q));
        accept_c    = press_q && lock_free_c;
        btn_d       = accept_c;
        roll_d      = defer_q || (tick_c && !accept_c);
        defer_d     = tick_c && accept_c;
        lock_d      = lock_q;
        if (accept_c) begin
            lock_d = LOCK_INIT;
        end else if (roll_d && !lock_zero_c) begin
            lock_d = lock_q - LOCK_W'(1);
        end
        stable_d  = (state_q == S_PRESSED) || (state_q == S_WAIT_LO);
        lockact_d = !lock_zero_c;
    end

    // Divider, lockout and registered output flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            lock_q    <= '0;
            defer_q   <= 1'b0;
            roll_q    <= 1'b0;
            btn_q     <= 1'b0;
            stable_q  <= 1'b0;
            lockact_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            lock_q    <= lock_d;
            defer_q   <= defer_d;
            roll_q    <= roll_d;
            btn_q     <= btn_d;
            stable_q  <= stable_d;
            lockact_q <= lockact_d;
        end
    end

    assign roll           = roll_q;
    assign btn            = btn_q;
    assign btn_stable     = stable_q;
    assign lockout_active = lockact_q;

endmodule

// File: tb/tb_tick_btn_conditioner.sv
// Self-checking bench for tick_btn_conditioner: directed scenarios plus a
// randomized tail, all compared cycle by cycle against a behavioural model.
module tb_tick_btn_conditioner;

    localparam int unsigned TICK_DIV      = 10;
    localparam int unsigned DEB_CYCLES    = 4;
    localparam int unsigned LOCKOUT_TICKS = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic ena;
    logic btn_raw;
    logic roll, btn, btn_stable, lockout_active;

    tick_btn_conditioner #(
        .TICK_DIV      (TICK_DIV),
        .DEB_CYCLES    (DEB_CYCLES),
        .LOCKOUT_TICKS (LOCKOUT_TICKS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ena            (ena),
        .btn_raw        (btn_raw),
        .roll           (roll),
        .btn            (btn),
        .btn_stable     (btn_stable),
        .lockout_active (lockout_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int n_btn = 0, n_roll = 0;
    int last_btn_edge = -1, last_roll_edge = -1;
    int rolls_since_btn = 0;

    // Reference model: enabled-cycle count for ticks, run length of the
    // opposite synced level for debouncing, remaining-roll count for lockout.
    int m_en_cnt = 0, m_lock = 0, m_run = 0;
    bit m_level = 0, m_press = 0, m_defer = 0, m_r1 = 0, m_r2 = 0;
    bit e_roll = 0, e_btn = 0, e_stable = 0, e_lock = 0;

    task automatic model_reset();
        m_en_cnt = 0; m_lock = 0; m_run = 0;
        m_level = 0; m_press = 0; m_defer = 0; m_r1 = 0; m_r2 = 0;
        e_roll = 0; e_btn = 0; e_stable = 0; e_lock = 0;
    endtask

    task automatic model_step();
        bit b, tick, accept, rl;
        b    = m_r2;
        m_r2 = m_r1;
        m_r1 = btn_raw;
        e_stable = m_level;
        e_lock   = (m_lock != 0);
        tick = ena && ((m_en_cnt % TICK_DIV) == TICK_DIV - 1);
        if (ena) m_en_cnt++;
        accept = m_press && (m_lock == 0 || (m_lock == 1 && (tick || m_defer)));
        rl     = m_defer || (tick && !accept);
        e_btn  = accept;
        e_roll = rl;
        m_defer = tick && accept;
        if (accept) m_lock = LOCKOUT_TICKS;
        else if (rl && m_lock > 0) m_lock--;
        m_press = 0;
        if (b != m_level) begin
            m_run++;
            if (m_run == DEB_CYCLES + 1) begin
                m_level = b;
                m_run   = 0;
                m_press = b;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @edge %0d: observed=%0d expected=%0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        edge_n++;
        if (reset_n) model_step();
        #1;
        chk("roll", 32'(roll), 32'(e_roll));
        chk("btn", 32'(btn), 32'(e_btn));
        chk("btn_stable", 32'(btn_stable), 32'(e_stable));
        chk("lockout_active", 32'(lockout_active), 32'(e_lock));
        if (btn === 1'b1) begin
            n_btn++;
            last_btn_edge = edge_n;
            rolls_since_btn = 0;
        end
        if (roll === 1'b1) begin
            n_roll++;
            last_roll_edge = edge_n;
            rolls_since_btn++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_lock_fall(output bit fell);
        fell = 1'b0;
        for (int i = 0; i < 80 && !fell; i++) begin
            cyc();
            fell = (lockout_active === 1'b0);
        end
    endtask

    task automatic wait_roll(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = (roll === 1'b1);
        end
    endtask

    initial begin
        int b0, p, n_edge, r_edge;
        bit ok;

        // Reset
        reset_n = 1'b0;
        ena     = 1'b1;
        btn_raw = 1'b0;
        model_reset();
        run(3);
        reset_n = 1'b1;
        edge_n  = 0;

        // Divider: roll on every 10th edge, nothing else active
        for (int i = 0; i < 35; i++) begin
            cyc();
            chk("div_roll_phase", 32'(roll), 32'(edge_n % 10 == 0));
            chk("div_btn_idle", 32'(btn), 32'd0);
            chk("div_lock_idle", 32'(lockout_active), 32'd0);
        end
        chk("div_roll_count", 32'(n_roll), 32'd3);

        // Clean press held 20 cycles
        b0 = n_btn;
        btn_raw = 1'b1;
        p = edge_n + 1;
        run(20);
        btn_raw = 1'b0;
        chk("press_count", 32'(n_btn - b0), 32'd1);
        chk("press_latency", 32'(last_btn_edge - p), 32'(DEB_CYCLES + 3));
        wait_lock_fall(ok);
        chk("press_lock_fell", 32'(ok), 32'd1);
        chk("press_lock_rolls", 32'(rolls_since_btn), 32'(LOCKOUT_TICKS));
        chk("press_lock_fall_edge", 32'(edge_n - last_roll_edge), 32'd1);

        // Bounce rejection: 1, 2, 3 cycle highs with 2-cycle lows
        run(10);
        b0 = n_btn;
        for (int len = 1; len <= 3; len++) begin
            btn_raw = 1'b1;
            repeat (len) begin cyc(); chk("bounce_stable", 32'(btn_stable), 32'd0); end
            btn_raw = 1'b0;
            repeat (2) begin cyc(); chk("bounce_stable", 32'(btn_stable), 32'd0); end
        end
        repeat (10) begin cyc(); chk("bounce_stable", 32'(btn_stable), 32'd0); end
        chk("bounce_btn", 32'(n_btn - b0), 32'd0);

        // Lockout drop: second press one tick after an accepted press
        while (edge_n % 10 != 3) cyc();
        btn_raw = 1'b1;
        run(8);
        btn_raw = 1'b0;
        b0 = n_btn;
        chk("drop_first_accepted", 32'(last_btn_edge), 32'(edge_n));
        wait_roll(ok);
        chk("drop_roll_seen", 32'(ok), 32'd1);
        btn_raw = 1'b1;
        run(8);
        btn_raw = 1'b0;
        wait_lock_fall(ok);
        chk("drop_lock_fell", 32'(ok), 32'd1);
        chk("drop_no_btn", 32'(n_btn - b0), 32'd0);
        chk("drop_no_reload", 32'(edge_n - last_btn_edge), 32'd30);
        chk("drop_lock_rolls", 32'(rolls_since_btn), 32'(LOCKOUT_TICKS));
        run(3);
        btn_raw = 1'b1;
        run(8);
        btn_raw = 1'b0;
        run(2);
        chk("drop_third_accepted", 32'(n_btn - b0), 32'd1);

        // Collision: press event aligned with the divider wrap
        wait_lock_fall(ok);
        chk("coll_lock_idle", 32'(ok), 32'd1);
        while (edge_n % 10 != 2) cyc();
        btn_raw = 1'b1;
        run(8);
        btn_raw = 1'b0;
        n_edge = edge_n;
        chk("coll_btn_at_wrap", 32'(btn), 32'd1);
        chk("coll_roll_held", 32'(roll), 32'd0);
        cyc();
        chk("coll_roll_deferred", 32'(roll), 32'd1);
        chk("coll_btn_single", 32'(btn), 32'd0);
        wait_roll(ok);
        chk("coll_next_roll", 32'(edge_n - n_edge), 32'd10);
        wait_lock_fall(ok);
        chk("coll_lock_fall", 32'(edge_n - n_edge), 32'd21);

        // ena low for 15 cycles holds the divider phase
        wait_roll(ok);
        r_edge = edge_n;
        ena = 1'b0;
        repeat (15) begin cyc(); chk("ena_no_roll", 32'(roll), 32'd0); end
        ena = 1'b1;
        wait_roll(ok);
        chk("ena_phase_kept", 32'(edge_n - r_edge), 32'd25);

        // Reset asserted while in WAIT_HI
        run(10);
        btn_raw = 1'b1;
        run(3);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_roll", 32'(roll), 32'd0);
        chk("rst_btn", 32'(btn), 32'd0);
        chk("rst_stable", 32'(btn_stable), 32'd0);
        chk("rst_lock", 32'(lockout_active), 32'd0);
        btn_raw = 1'b0;
        run(2);
        reset_n = 1'b1;
        b0 = n_btn;
        run(20);
        chk("rst_no_btn", 32'(n_btn - b0), 32'd0);

        // Randomized button segments and enable dropouts
        for (int s = 0; s < 90; s++) begin
            btn_raw = 1'($urandom_range(0, 1));
            ena     = ($urandom_range(0, 9) != 0);
            run(int'($urandom_range(1, 12)));
        end
        btn_raw = 1'b0;
        ena     = 1'b1;
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
